// File: rtl/router_pkg.sv
// Shared types and helpers for the wire_router block: width helper, FSM
// encoding and the power-on routing map.
package router_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      COMMIT = 1'b1
   } state_t;

   // Index width for n items, never narrower than one bit.
   function automatic int width_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int default_map(input int j, input int n_in);
      return j % n_in;
   endfunction

endpackage

// File: rtl/router_mux.sv
// One N_IN-to-1 channel selector, W bits wide, purely combinational.
module router_mux
   import router_pkg::*;
#(
   parameter  int N_IN = 3,
   parameter  int W    = 1,
   localparam int IW   = width_of(N_IN)
)
(
   input  logic [N_IN*W-1:0] i_in,
   input  logic [IW-1:0]     i_sel,
   output logic [W-1:0]      o_out
);

   // Out-of-range selects cannot reach here; they fall back to zero.
   always_comb begin
      o_out = '0;
      for (int k = 0; k < N_IN; k++) begin
         if (int'(i_sel) == k) begin
            o_out = i_in[k*W +: W];
         end
      end
   end

endmodule

// File: rtl/wire_router.sv
// Registered N_IN-to-N_OUT channel router with a shadow routing table that is
// copied to the active table atomically on commit.
module wire_router
   import router_pkg::*;
#(
   parameter  int N_IN  = 3,
   parameter  int N_OUT = 4,
   parameter  int W     = 1,
   localparam int IW    = width_of(N_IN),
   localparam int OW    = width_of(N_OUT)
)
(
   input  logic               clk,
   input  logic               resetn,
   input  logic [N_IN*W-1:0]  in,
   output logic [N_OUT*W-1:0] out,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [OW-1:0]      cfg_idx,
   input  logic [IW-1:0]      cfg_sel,
   input  logic               cfg_commit,
   output logic               cfg_err
);

   state_t             r_state;
   state_t             w_state_next;
   logic               r_ready;
   logic               w_ready_next;
   logic               r_err;
   logic               w_err_next;
   logic               w_accept;
   logic               w_req_ok;
   logic               w_write;
   logic               w_commit;
   logic [IW-1:0]      r_shadow      [N_OUT];
   logic [IW-1:0]      r_active      [N_OUT];
   logic [IW-1:0]      w_shadow_next [N_OUT];
   logic [N_OUT*W-1:0] w_mux_out;
   logic [N_OUT*W-1:0] r_out;

   assign w_accept = cfg_valid && r_ready;
   assign w_req_ok = (int'(cfg_idx) < N_OUT) && (int'(cfg_sel) < N_IN);

   always_comb begin
      w_state_next = r_state;
      w_err_next   = 1'b0;
      w_write      = 1'b0;
      w_commit     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_req_ok) begin
                  w_write = 1'b1;
                  if (cfg_commit) begin
                     w_commit     = 1'b1;
                     w_state_next = COMMIT;
                  end
               end else begin
                  w_err_next = 1'b1;
               end
            end
         end
         COMMIT:  w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
      w_ready_next = (w_state_next == IDLE);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_ready <= w_ready_next;
         r_err   <= w_err_next;
      end
   end

   // The committed copy must include the write arriving in the same cycle.
   genvar gi;
   generate
      for (gi = 0; gi < N_OUT; gi++) begin : g_chan
         assign w_shadow_next[gi] = (w_write && (int'(cfg_idx) == gi)) ? cfg_sel : r_shadow[gi];

         router_mux #(
            .N_IN (N_IN),
            .W    (W)
         ) u_mux (
            .i_in  (in),
            .i_sel (r_active[gi]),
            .o_out (w_mux_out[gi*W +: W])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_out <= '0;
         for (int j = 0; j < N_OUT; j++) begin
            r_shadow[j] <= IW'(default_map(j, N_IN));
            r_active[j] <= IW'(default_map(j, N_IN));
         end
      end else begin
         r_out <= w_mux_out;
         for (int j = 0; j < N_OUT; j++) begin
            r_shadow[j] <= w_shadow_next[j];
            if (w_commit) begin
               r_active[j] <= w_shadow_next[j];
            end
         end
      end
   end

   assign out       = r_out;
   assign cfg_ready = r_ready;
   assign cfg_err   = r_err;

endmodule

// File: tb/tb_wire_router.sv
// Directed plus randomized bench for wire_router: a 3x4x1 instance against a
// table-based reference model, and a 5x2x8 instance with directed checks.
module tb_wire_router;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn;
   logic [2:0]  a_in;
   logic [3:0]  a_out;
   logic        a_valid, a_ready, a_commit, a_err;
   logic [1:0]  a_idx;
   logic [1:0]  a_sel;

   logic [39:0] b_in;
   logic [15:0] b_out;
   logic        b_valid, b_ready, b_commit, b_err;
   logic [0:0]  b_idx;
   logic [2:0]  b_sel;

   wire_router #(.N_IN(3), .N_OUT(4), .W(1)) u_dut_a (
      .clk        (clk),
      .resetn     (resetn),
      .in         (a_in),
      .out        (a_out),
      .cfg_valid  (a_valid),
      .cfg_ready  (a_ready),
      .cfg_idx    (a_idx),
      .cfg_sel    (a_sel),
      .cfg_commit (a_commit),
      .cfg_err    (a_err)
   );

   wire_router #(.N_IN(5), .N_OUT(2), .W(8)) u_dut_b (
      .clk        (clk),
      .resetn     (resetn),
      .in         (b_in),
      .out        (b_out),
      .cfg_valid  (b_valid),
      .cfg_ready  (b_ready),
      .cfg_idx    (b_idx),
      .cfg_sel    (b_sel),
      .cfg_commit (b_commit),
      .cfg_err    (b_err)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: routing tables as plain integer arrays.
   int       m_sh [4];
   int       m_ac [4];
   logic [3:0] m_out;
   logic     m_ready;
   logic     m_err;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      logic acc;
      logic ok;
      if (!resetn) begin
         m_out   = '0;
         m_ready = 1'b0;
         m_err   = 1'b0;
         for (int j = 0; j < 4; j++) begin
            m_sh[j] = j % 3;
            m_ac[j] = j % 3;
         end
      end else begin
         for (int j = 0; j < 4; j++) m_out[j] = a_in[m_ac[j]];
         acc   = a_valid && m_ready;
         ok    = (int'(a_idx) < 4) && (int'(a_sel) < 3);
         m_err = acc && !ok;
         if (acc) $display("txn idx=%0d sel=%0d commit=%0d accepted=%0d", a_idx, a_sel, a_commit, ok);
         if (acc && ok) begin
            m_sh[a_idx] = int'(a_sel);
            if (a_commit) m_ac = m_sh;
         end
         m_ready = !(acc && ok && a_commit);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      chk("a_out", 64'(a_out), 64'(m_out));
      chk("a_ready", 64'(a_ready), 64'(m_ready));
      chk("a_err", 64'(a_err), 64'(m_err));
   endtask

   initial begin
      resetn   = 1'b0;
      a_in     = '0; a_valid = 1'b0; a_idx = '0; a_sel = '0; a_commit = 1'b0;
      b_in     = '0; b_valid = 1'b0; b_idx = '0; b_sel = '0; b_commit = 1'b0;

      // Reset state
      cycle();
      cycle();
      chk("rst_out", 64'(a_out), 64'h0);
      chk("rst_ready", 64'(a_ready), 64'h0);
      chk("rst_b_out", 64'(b_out), 64'h0);
      chk("rst_b_ready", 64'(b_ready), 64'h0);
      resetn = 1'b1;
      cycle();
      chk("first_ready", 64'(a_ready), 64'h1);

      // Default map
      a_in = 3'b111; cycle(); chk("map_111", 64'(a_out), 64'hF);
      a_in = 3'b101; cycle(); chk("map_101", 64'(a_out), 64'hD);
      a_in = 3'b000; cycle(); chk("map_000", 64'(a_out), 64'h0);

      // Shadow isolation, then commit
      a_in = 3'b101; cycle();
      a_valid = 1'b1; a_idx = 2'd3; a_sel = 2'd1; a_commit = 1'b0;
      cycle();
      chk("shadow_out", 64'(a_out), 64'hD);
      chk("shadow_ready", 64'(a_ready), 64'h1);
      a_valid = 1'b0; cycle();
      chk("shadow_hold", 64'(a_out), 64'hD);
      a_valid = 1'b1; a_commit = 1'b1;
      cycle();
      chk("commit_ready_low", 64'(a_ready), 64'h0);
      chk("commit_out_k", 64'(a_out), 64'hD);
      a_valid = 1'b0; a_commit = 1'b0;
      cycle();
      chk("commit_out_k1", 64'(a_out), 64'h5);

      // Invalid request
      a_valid = 1'b1; a_idx = 2'd0; a_sel = 2'd3; a_commit = 1'b1;
      cycle();
      chk("inv_err", 64'(a_err), 64'h1);
      chk("inv_ready", 64'(a_ready), 64'h1);
      a_valid = 1'b0; a_commit = 1'b0;
      cycle();
      chk("inv_err_clear", 64'(a_err), 64'h0);
      chk("inv_out", 64'(a_out), 64'h5);

      // Held commit request
      a_valid = 1'b1; a_idx = 2'd0; a_sel = 2'd2; a_commit = 1'b1; a_in = 3'b100;
      cycle(); chk("hold_k", 64'(a_ready), 64'h0);
      cycle(); chk("hold_k1", 64'(a_ready), 64'h1);
      cycle(); chk("hold_k2", 64'(a_ready), 64'h0);
      a_valid = 1'b0; a_commit = 1'b0;
      cycle(); chk("hold_out0_hi", 64'(a_out[0]), 64'h1);
      a_in = 3'b011;
      cycle(); chk("hold_out0_lo", 64'(a_out[0]), 64'h0);

      // Reset during COMMIT
      a_valid = 1'b1; a_idx = 2'd1; a_sel = 2'd0; a_commit = 1'b1;
      cycle();
      a_valid = 1'b0; a_commit = 1'b0; resetn = 1'b0;
      cycle();
      chk("rstc_out", 64'(a_out), 64'h0);
      chk("rstc_ready", 64'(a_ready), 64'h0);
      resetn = 1'b1; a_in = 3'b101;
      cycle();
      chk("rstc_map", 64'(a_out), 64'hD);

      // Wide build
      b_in = {8'hA5, 8'h11, 8'h22, 8'h33, 8'h3C};
      b_valid = 1'b1; b_idx = 1'b1; b_sel = 3'd4; b_commit = 1'b1;
      cycle();
      chk("wide_ready_low", 64'(b_ready), 64'h0);
      chk("wide_out_old", 64'(b_out), 64'h333C);
      b_valid = 1'b0; b_commit = 1'b0;
      cycle();
      chk("wide_out_new", 64'(b_out), 64'hA53C);
      b_valid = 1'b1; b_idx = 1'b0; b_sel = 3'd5;
      cycle();
      chk("wide_err", 64'(b_err), 64'h1);
      b_valid = 1'b0;
      cycle();
      chk("wide_err_clear", 64'(b_err), 64'h0);
      chk("wide_out_kept", 64'(b_out), 64'hA53C);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         resetn   = ($urandom_range(0, 59) != 0);
         a_valid  = 1'($urandom_range(0, 1));
         a_idx    = 2'($urandom_range(0, 3));
         a_sel    = 2'($urandom_range(0, 3));
         a_commit = 1'($urandom_range(0, 1));
         a_in     = 3'($urandom_range(0, 7));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
